// File: rtl/core_loader.sv
// core_loader: loads an image into data memory, runs the core with a timeout, then streams the result region out
module core_loader #(
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_LEN   = 32,
    parameter int TIMEOUT   = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_sel,
    output logic       mem_we,
    output logic       mem_re,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       core_start,
    input  logic       core_done,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       error
);
    typedef enum logic [2:0] {LOAD, START, RUN, DUMP_RD, DUMP_OUT, DONE, ERR} state_t;
    localparam logic [7:0] LOAD_B = 8'(LOAD_BASE);
    localparam logic [7:0] LOAD_LAST = 8'(LOAD_LEN - 1);
    localparam logic [7:0] RES_B = 8'(RES_BASE);
    localparam logic [7:0] RES_LAST = 8'(RES_LEN - 1);
    localparam logic [15:0] RUN_MAX = 16'(TIMEOUT);
    state_t state, state_next;
    logic [7:0] cnt, idx, wr_addr, data_q;
    logic [15:0] run_cnt;
    logic fresh, accept;
    always_comb begin
        accept = in_valid && in_ready;
        state_next = state;
        case (state)
            LOAD:     state_next = accept && cnt == LOAD_LAST ? START : LOAD;
            START:    state_next = RUN;
            RUN:      state_next = core_done ? DUMP_RD : run_cnt == RUN_MAX ? ERR : RUN;
            DUMP_RD:  state_next = DUMP_OUT;
            DUMP_OUT: state_next = !out_ready ? DUMP_OUT : idx == RES_LAST ? DONE : DUMP_RD;
            default:  state_next = state;
        endcase
        core_start = state != RUN;
        mem_sel = state != RUN;
        busy = state != DONE && state != ERR;
        error = state == ERR;
        out_valid = state == DUMP_OUT;
        mem_re = state == DUMP_RD;
        mem_addr = mem_re ? RES_B + idx : wr_addr;
        // read data is only valid the cycle after mem_re, so later cycles replay the captured copy
        out_data = fresh ? mem_rdata : data_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD;
            in_ready <= 1'b0;
            mem_we <= 1'b0;
            wr_addr <= 8'd0;
            mem_wdata <= 8'd0;
            cnt <= 8'd0;
            idx <= 8'd0;
            run_cnt <= 16'd0;
            fresh <= 1'b0;
            data_q <= 8'd0;
        end else begin
            state <= state_next;
            in_ready <= state_next == LOAD;
            mem_we <= accept;
            if (accept) begin
                wr_addr <= LOAD_B + cnt;
                mem_wdata <= in_data;
                cnt <= cnt + 8'd1;
            end
            run_cnt <= state == RUN ? run_cnt + 16'd1 : 16'd0;
            fresh <= state == DUMP_RD;
            if (fresh) data_q <= mem_rdata;
            if (state == DUMP_OUT && out_ready) idx <= idx + 8'd1;
        end
    end
endmodule

// File: doc/core_loader.md
CORE_LOADER -- requirements
Module: core_loader

Interface
REQ-001 Parameter LOAD_BASE, default 0, first data-memory address written during load.
REQ-002 Parameter LOAD_LEN, default 64, bytes loaded (1..256; LOAD_BASE+LOAD_LEN <= 256).
REQ-003 Parameter RES_BASE, default 64, first data-memory address read during dump.
REQ-004 Parameter RES_LEN, default 32, bytes dumped (1..256; RES_BASE+RES_LEN <= 256).
REQ-005 Parameter TIMEOUT, default 4095, max core run cycles before error (1..65535).
REQ-006 Ports: one clock; reset is synchronous and active-low.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-low; low at a rising edge resets all state.
REQ-009 in_valid  input  1  load byte present.
REQ-010 in_data  input  8  load byte.
REQ-011 in_ready  output  1  loader accepts in_data this cycle.
REQ-012 mem_sel  output  1  loader owns the data-memory port (1) or the core does (0).
REQ-013 mem_we  output  1  data-memory write strobe.
REQ-014 mem_re  output  1  data-memory read strobe.
REQ-015 mem_addr  output  8  data-memory address.
REQ-016 mem_wdata  output  8  data-memory write data.
REQ-017 mem_rdata  input  8  data-memory read data, valid the cycle after mem_re.
REQ-018 core_start  output  1  held high to keep the core's PC at reset; low lets it run.
REQ-019 core_done  input  1  core finished.
REQ-020 out_valid  output  1  result byte present.
REQ-021 out_data  output  8  result byte.
REQ-022 out_ready  input  1  consumer accepts out_data.
REQ-023 busy  output  1  high in every state except DONE and ERR.
REQ-024 error  output  1  run timed out; sticky until reset.

Function
REQ-025 FSM states LOAD, START, RUN, DUMP_RD, DUMP_OUT, DONE, ERR; reset state LOAD.
REQ-026 Reset values: in_ready=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, out_valid=0, out_data=0, core_start=1, mem_sel=1, busy=1, error=0; counters=0.
REQ-027 LOAD: in_ready=1; on in_valid&in_ready, one-cycle write: mem_we=1, mem_addr=LOAD_BASE+cnt, mem_wdata=in_data next cycle; cnt+1.
REQ-028 LOAD: once byte LOAD_LEN-1 is accepted, next state START and in_ready=0; no further bytes accepted.
REQ-029 START: one cycle; mem_we=0, core_start=1; next state RUN.
REQ-030 RUN: core_start=0, mem_sel=0, mem_we=0, mem_re=0; run counter increments each cycle from 0.
REQ-031 RUN: core_done=1 -> DUMP_RD; else run counter = TIMEOUT -> ERR; core_done and timeout in same cycle -> DUMP_RD.
REQ-032 core_done is ignored in LOAD and START; in_valid is ignored outside LOAD.
REQ-033 DUMP_RD: mem_sel=1, core_start=1, mem_re=1 for one cycle at RES_BASE+idx; next state DUMP_OUT.
REQ-034 DUMP_OUT: out_valid=1, out_data=mem_rdata captured from preceding read; out_data stable while out_valid&!out_ready.
REQ-035 DUMP_OUT: on out_ready, idx+1; -> DUMP_RD if more bytes, else DONE; throughput 1 byte per 2 cycles max.
REQ-036 DONE: busy=0, core_start=1, mem_sel=1, all strobes 0; held until reset.
REQ-037 ERR: error=1, busy=0, core_start=1, mem_sel=1, all strobes 0; held until reset.
REQ-038 Address arithmetic 8-bit unsigned; parameter constraints guarantee no wrap.

Reset
REQ-039 reset low in any state, including mid-write or mid-dump, returns to LOAD with REQ-026 values next cycle; no write or output issued on that cycle.
REQ-040 Bytes loaded before a mid-operation reset are not re-counted; loading restarts at LOAD_BASE.

Verification
REQ-041 LOAD_LEN=4, bytes 0x11,0x22,0x33,0x44 with in_valid gaps -> writes to addr 0..3 in order, START one cycle, core_start falls entering RUN.
REQ-042 core_done after 10 RUN cycles, mem 64..95 = 0x00..0x1F, out_ready=1 -> 32 bytes 0x00..0x1F, then DONE, busy=0.
REQ-043 out_ready low 5 cycles during byte 3 -> out_valid held, out_data stable at 0x03, no skip/duplicate.
REQ-044 TIMEOUT=8, core_done never -> ERR after 8 RUN cycles, error=1, busy=0; core_done at cycle 8 -> DUMP_RD instead.
REQ-045 reset low during load byte 2 and during dump byte 5 -> back to LOAD, cnt=0, out_valid=0, next byte written to LOAD_BASE.
